// File: rtl/voice_allocator_pkg.sv
// Shared configuration for the voice allocator: voice count, note/velocity types,
// per-voice state and the control FSM encoding.
package voice_allocator_pkg;

    localparam int PIPELINE_COUNT = 4;
    localparam int VOICE_COUNT    = PIPELINE_COUNT;
    localparam int NOTE_WIDTH     = 7;
    localparam int RANK_WIDTH     = $clog2(VOICE_COUNT);

    typedef logic [6:0]            percent_t;
    typedef logic [NOTE_WIDTH-1:0] note_t;
    typedef logic [RANK_WIDTH-1:0] rank_t;
    typedef logic [RANK_WIDTH-1:0] idx_t;

    typedef enum logic [1:0] {
        FREE      = 2'd0,
        GATED     = 2'd1,
        RELEASING = 2'd2
    } voice_state_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_COMMIT = 2'd2
    } ctrl_state_t;

    // Event as latched at accept; a note-on with velocity 0 is stored as a note-off.
    typedef struct packed {
        logic     on;
        note_t    note;
        percent_t velocity;
    } note_event_t;

endpackage

// File: rtl/voice_allocator_if.sv
// Note-event handshake between the MIDI parser (master) and the voice allocator (slave).
interface voice_allocator_if;
    import voice_allocator_pkg::*;

    logic     event_valid;
    logic     event_ready;
    logic     event_on;
    note_t    event_note;
    percent_t event_velocity;

    modport master (
        output event_valid,
        output event_on,
        output event_note,
        output event_velocity,
        input  event_ready
    );

    modport slave (
        input  event_valid,
        input  event_on,
        input  event_note,
        input  event_velocity,
        output event_ready
    );

endinterface

// File: rtl/voice_allocator_select.sv
// Combinational target search: same-note retrigger, lowest free voice, oldest
// releasing voice, then oldest gated voice. Also returns the note-off match mask.
module voice_allocator_select
    import voice_allocator_pkg::*;
(
    input  voice_state_t [VOICE_COUNT-1:0] state,
    input  note_t        [VOICE_COUNT-1:0] note,
    input  rank_t        [VOICE_COUNT-1:0] rank,
    input  note_t                          event_note,
    output idx_t                           target,
    output logic                           steal,
    output logic         [VOICE_COUNT-1:0] off_mask
);

    logic  hit_found, free_found, rel_found, gat_found;
    idx_t  hit_idx, free_idx, rel_idx, gat_idx;
    rank_t rel_rank, gat_rank;

    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        hit_found  = 1'b0;
        free_found = 1'b0;
        rel_found  = 1'b0;
        gat_found  = 1'b0;
        hit_idx    = '0;
        free_idx   = '0;
        rel_idx    = '0;
        gat_idx    = '0;
        rel_rank   = '0;
        gat_rank   = '0;
        off_mask   = '0;
        target     = '0;
        steal      = 1'b0;

        for (int i = 0; i < VOICE_COUNT; i++) begin
            if (state[i] != FREE && note[i] == event_note && !hit_found) begin
                hit_found = 1'b1;
                hit_idx   = idx_t'(i);
            end
            if (state[i] == GATED && note[i] == event_note) begin
                off_mask[i] = 1'b1;
            end
            if (state[i] == FREE && !free_found) begin
                free_found = 1'b1;
                free_idx   = idx_t'(i);
            end
            // Lower rank is older; rank values are unique so ties cannot occur.
            if (state[i] == RELEASING && (!rel_found || rank[i] < rel_rank)) begin
                rel_found = 1'b1;
                rel_rank  = rank[i];
                rel_idx   = idx_t'(i);
            end
            if (state[i] == GATED && (!gat_found || rank[i] < gat_rank)) begin
                gat_found = 1'b1;
                gat_rank  = rank[i];
                gat_idx   = idx_t'(i);
            end
        end

        if (hit_found) begin
            target = hit_idx;
        end else if (free_found) begin
            target = free_idx;
        end else if (rel_found) begin
            target = rel_idx;
            steal  = 1'b1;
        end else begin
            target = gat_idx;
            steal  = 1'b1;
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Voice allocator: accepts note events, assigns note-ons to voices (stealing the
// oldest when full), releases on note-off and frees voices when their envelope finishes.
module voice_allocator
    import voice_allocator_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    voice_allocator_if.slave               ev,
    input  logic                           panic,
    input  logic         [VOICE_COUNT-1:0] voice_done,
    output logic         [VOICE_COUNT-1:0] voice_gate,
    output logic         [VOICE_COUNT-1:0] voice_trigger,
    output note_t        [VOICE_COUNT-1:0] voice_note,
    output percent_t     [VOICE_COUNT-1:0] voice_velocity,
    output logic                           voice_stolen
);

    ctrl_state_t                     ctrl;
    note_event_t                     evt;
    voice_state_t [VOICE_COUNT-1:0]  vstate;
    rank_t        [VOICE_COUNT-1:0]  rank;

    idx_t                            tgt_idx;
    logic                            tgt_steal;
    logic         [VOICE_COUNT-1:0]  tgt_off_mask;

    idx_t                            sel_idx;
    logic                            sel_steal;
    logic         [VOICE_COUNT-1:0]  sel_off_mask;

    voice_allocator_select u_select (
        .state      (vstate),
        .note       (voice_note),
        .rank       (rank),
        .event_note (evt.note),
        .target     (sel_idx),
        .steal      (sel_steal),
        .off_mask   (sel_off_mask)
    );

    assign ev.event_ready = (ctrl == ST_IDLE) && !panic;

    always_comb begin
        voice_gate = '0;
        for (int i = 0; i < VOICE_COUNT; i++) begin
            voice_gate[i] = (vstate[i] == GATED);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; later writes in this block override earlier ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl           <= ST_IDLE;
            evt            <= '0;
            tgt_idx        <= '0;
            tgt_steal      <= 1'b0;
            tgt_off_mask   <= '0;
            voice_trigger  <= '0;
            voice_stolen   <= 1'b0;
            voice_note     <= '0;
            voice_velocity <= '0;
            // NOTE: the per-voice arrays are a handful of flops, so all of them are reset rather than left unknown.
            for (int i = 0; i < VOICE_COUNT; i++) begin
                vstate[i] <= FREE;
                rank[i]   <= rank_t'(i);
            end
        end else begin
            voice_trigger <= '0;
            voice_stolen  <= 1'b0;

            for (int i = 0; i < VOICE_COUNT; i++) begin
                if (voice_done[i] && vstate[i] == RELEASING) begin
                    vstate[i] <= FREE;
                end
            end

            if (panic) begin
                ctrl <= ST_IDLE;
                for (int i = 0; i < VOICE_COUNT; i++) begin
                    if (vstate[i] == GATED) begin
                        vstate[i] <= RELEASING;
                    end
                end
            end else begin
                unique case (ctrl)
                    ST_IDLE: begin
                        if (ev.event_valid) begin
                            evt  <= '{on:       ev.event_on && (ev.event_velocity != '0),
                                      note:     ev.event_note,
                                      velocity: ev.event_velocity};
                            ctrl <= ST_SEARCH;
                        end
                    end

                    ST_SEARCH: begin
                        tgt_idx      <= sel_idx;
                        tgt_steal    <= sel_steal;
                        tgt_off_mask <= sel_off_mask;
                        ctrl         <= ST_COMMIT;
                    end

                    ST_COMMIT: begin
                        ctrl <= ST_IDLE;
                        if (evt.on) begin
                            // Overrides any same-cycle voice_done on the target.
                            vstate[tgt_idx]         <= GATED;
                            voice_note[tgt_idx]     <= evt.note;
                            voice_velocity[tgt_idx] <= evt.velocity;
                            voice_trigger[tgt_idx]  <= 1'b1;
                            voice_stolen            <= tgt_steal;
                            for (int j = 0; j < VOICE_COUNT; j++) begin
                                if (idx_t'(j) == tgt_idx) begin
                                    rank[j] <= rank_t'(VOICE_COUNT - 1);
                                end else if (rank[j] > rank[tgt_idx]) begin
                                    rank[j] <= rank[j] - 1'b1;
                                end
                            end
                        end else begin
                            for (int i = 0; i < VOICE_COUNT; i++) begin
                                if (tgt_off_mask[i] && vstate[i] == GATED) begin
                                    vstate[i] <= RELEASING;
                                end
                            end
                        end
                    end

                    default: ctrl <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed scenarios plus a randomized
// run, all checked against an age-list reference model of the allocation rules.
module tb_voice_allocator;
    import voice_allocator_pkg::*;

    localparam int M_FREE  = 0;
    localparam int M_GATED = 1;
    localparam int M_REL   = 2;

    logic                          clk        = 1'b0;
    logic                          rst_n      = 1'b0;
    logic                          panic      = 1'b0;
    logic      [VOICE_COUNT-1:0]   voice_done = '0;
    logic      [VOICE_COUNT-1:0]   voice_gate;
    logic      [VOICE_COUNT-1:0]   voice_trigger;
    note_t     [VOICE_COUNT-1:0]   voice_note;
    percent_t  [VOICE_COUNT-1:0]   voice_velocity;
    logic                          voice_stolen;

    voice_allocator_if bus ();

    voice_allocator dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ev             (bus.slave),
        .panic          (panic),
        .voice_done     (voice_done),
        .voice_gate     (voice_gate),
        .voice_trigger  (voice_trigger),
        .voice_note     (voice_note),
        .voice_velocity (voice_velocity),
        .voice_stolen   (voice_stolen)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: per-voice state plus an age list, oldest voice first.
    int m_state [VOICE_COUNT];
    int m_note  [VOICE_COUNT];
    int m_vel   [VOICE_COUNT];
    int m_age   [$];

    logic [VOICE_COUNT-1:0] t_seen;
    logic                   s_seen;

    function automatic void model_reset();
        m_age.delete();
        for (int i = 0; i < VOICE_COUNT; i++) begin
            m_state[i] = M_FREE;
            m_note[i]  = 0;
            m_vel[i]   = 0;
            m_age.push_back(i);
        end
    endfunction

    function automatic int model_note_on(input int n, input int v, output bit steal);
        int idx = -1;
        int pos = 0;
        steal = 1'b0;
        for (int i = 0; i < VOICE_COUNT; i++)
            if (idx < 0 && m_state[i] != M_FREE && m_note[i] == n) idx = i;
        for (int i = 0; i < VOICE_COUNT; i++)
            if (idx < 0 && m_state[i] == M_FREE) idx = i;
        if (idx < 0) begin
            for (int k = 0; k < m_age.size(); k++)
                if (idx < 0 && m_state[m_age[k]] == M_REL) idx = m_age[k];
            if (idx < 0) idx = m_age[0];
            steal = 1'b1;
        end
        m_state[idx] = M_GATED;
        m_note[idx]  = n;
        m_vel[idx]   = v;
        for (int k = 0; k < m_age.size(); k++)
            if (m_age[k] == idx) pos = k;
        m_age.delete(pos);
        m_age.push_back(idx);
        return idx;
    endfunction

    function automatic void model_note_off(input int n);
        for (int i = 0; i < VOICE_COUNT; i++)
            if (m_state[i] == M_GATED && m_note[i] == n) m_state[i] = M_REL;
    endfunction

    function automatic void model_panic();
        for (int i = 0; i < VOICE_COUNT; i++)
            if (m_state[i] == M_GATED) m_state[i] = M_REL;
    endfunction

    function automatic logic [VOICE_COUNT-1:0] model_gate();
        logic [VOICE_COUNT-1:0] g = '0;
        for (int i = 0; i < VOICE_COUNT; i++) g[i] = (m_state[i] == M_GATED);
        return g;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n              = 1'b0;
        panic              = 1'b0;
        voice_done         = '0;
        bus.event_valid    = 1'b0;
        bus.event_on       = 1'b0;
        bus.event_note     = '0;
        bus.event_velocity = '0;
        step();
        step();
        rst_n = 1'b1;
        step();
        model_reset();
    endtask

    // Drives one event through accept/search/commit and checks every output after commit.
    task automatic send_event(input bit on, input int n, input int v,
                              input logic [VOICE_COUNT-1:0] commit_done, input string tag,
                              output logic [VOICE_COUNT-1:0] trig_seen, output logic stolen_seen);
        int waited = 0;
        int idx = -1;
        bit steal = 1'b0;
        int pre [VOICE_COUNT];
        logic [VOICE_COUNT-1:0] exp_trig = '0;
        logic [VOICE_COUNT-1:0] exp_gate;

        while (bus.event_ready !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        total++;
        if (bus.event_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s ready_timeout: event_ready=%b required 1", tag, bus.event_ready);
        end

        bus.event_valid    = 1'b1;
        bus.event_on       = on;
        bus.event_note     = note_t'(n);
        bus.event_velocity = percent_t'(v);
        step();
        bus.event_valid    = 1'b0;
        bus.event_on       = 1'b0;
        bus.event_note     = '0;
        bus.event_velocity = '0;

        total++;
        if (bus.event_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s ready_in_search: got %b required 0", tag, bus.event_ready);
        end
        step();
        voice_done = commit_done;
        total++;
        if (voice_trigger !== '0) begin
            bad++;
            $display("FAIL %s early_trigger: got %b required 0000", tag, voice_trigger);
        end
        step();
        voice_done = '0;

        pre = m_state;
        if (on && v != 0) begin
            idx = model_note_on(n, v, steal);
            exp_trig[idx] = 1'b1;
        end else begin
            model_note_off(n);
        end
        for (int i = 0; i < VOICE_COUNT; i++)
            if (commit_done[i] && pre[i] == M_REL && i != idx) m_state[i] = M_FREE;
        exp_gate = model_gate();

        total++;
        if (voice_trigger !== exp_trig) begin
            bad++;
            $display("FAIL %s trigger: got %b required %b", tag, voice_trigger, exp_trig);
        end
        total++;
        if (voice_stolen !== steal) begin
            bad++;
            $display("FAIL %s stolen: got %b required %b", tag, voice_stolen, steal);
        end
        total++;
        if (voice_gate !== exp_gate) begin
            bad++;
            $display("FAIL %s gate: got %b required %b", tag, voice_gate, exp_gate);
        end
        total++;
        if (bus.event_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s ready_after_commit: got %b required 1", tag, bus.event_ready);
        end
        for (int i = 0; i < VOICE_COUNT; i++) begin
            total++;
            if (voice_note[i] !== note_t'(m_note[i]) || voice_velocity[i] !== percent_t'(m_vel[i])) begin
                bad++;
                $display("FAIL %s voice%0d note/vel: got %0d/%0d required %0d/%0d",
                         tag, i, voice_note[i], voice_velocity[i], m_note[i], m_vel[i]);
            end
        end
        trig_seen   = voice_trigger;
        stolen_seen = voice_stolen;
    endtask

    task automatic pulse_done(input logic [VOICE_COUNT-1:0] mask, input string tag);
        voice_done = mask;
        step();
        voice_done = '0;
        for (int i = 0; i < VOICE_COUNT; i++)
            if (mask[i] && m_state[i] == M_REL) m_state[i] = M_FREE;
        total++;
        if (voice_gate !== model_gate() || voice_trigger !== '0) begin
            bad++;
            $display("FAIL %s done_pulse: gate=%b trig=%b required gate=%b trig=0000",
                     tag, voice_gate, voice_trigger, model_gate());
        end
    endtask

    task automatic do_panic(input int cycles, input string tag);
        panic = 1'b1;
        #1;
        total++;
        if (bus.event_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s ready_during_panic: got %b required 0", tag, bus.event_ready);
        end
        repeat (cycles) step();
        model_panic();
        total++;
        if (voice_gate !== model_gate() || voice_trigger !== '0) begin
            bad++;
            $display("FAIL %s panic_gate: gate=%b trig=%b required gate=%b trig=0000",
                     tag, voice_gate, voice_trigger, model_gate());
        end
        panic = 1'b0;
        #1;
        total++;
        if (bus.event_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s ready_after_panic: got %b required 1", tag, bus.event_ready);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (voice_gate !== '0 || voice_trigger !== '0 || voice_stolen !== 1'b0 ||
            voice_note !== '0 || voice_velocity !== '0 || bus.event_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_values: gate=%b trig=%b stolen=%b ready=%b required 0/0/0/1",
                     voice_gate, voice_trigger, voice_stolen, bus.event_ready);
        end
        send_event(1'b1, 50, 40, '0, "reset_pre", t_seen, s_seen);
        // Accept a second event, then reset while it sits in SEARCH.
        bus.event_valid    = 1'b1;
        bus.event_on       = 1'b1;
        bus.event_note     = note_t'(60);
        bus.event_velocity = percent_t'(90);
        step();
        bus.event_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (voice_gate !== '0 || voice_note !== '0 || voice_velocity !== '0) begin
            bad++;
            $display("FAIL reset_mid_event: gate=%b note0=%0d required gate=0000 note0=0",
                     voice_gate, voice_note[0]);
        end
        step();
        rst_n = 1'b1;
        model_reset();
        step();
        step();
        step();
        total++;
        if (voice_trigger !== '0 || voice_gate !== '0 || bus.event_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_event_dropped: trig=%b gate=%b ready=%b required 0000/0000/1",
                     voice_trigger, voice_gate, bus.event_ready);
        end
    endtask

    task automatic test_first_note();
        do_reset();
        send_event(1'b1, 60, 100, '0, "first_note", t_seen, s_seen);
        total++;
        if (t_seen !== 4'b0001 || voice_note[0] !== note_t'(60) || voice_velocity[0] !== percent_t'(100)) begin
            bad++;
            $display("FAIL first_note_literal: trig=%b note=%0d vel=%0d required 0001/60/100",
                     t_seen, voice_note[0], voice_velocity[0]);
        end
        step();
        total++;
        if (voice_trigger !== '0) begin
            bad++;
            $display("FAIL trigger_one_cycle: got %b required 0000", voice_trigger);
        end
    endtask

    task automatic test_steal_oldest();
        int notes [4] = '{60, 62, 64, 65};
        logic [VOICE_COUNT-1:0] exp_seq [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        int more [4] = '{67, 69, 71, 72};
        do_reset();
        foreach (notes[k]) send_event(1'b1, notes[k], 1 + $urandom_range(0, 126), '0, "fill", t_seen, s_seen);
        foreach (more[k]) begin
            send_event(1'b1, more[k], 80, '0, "steal_oldest", t_seen, s_seen);
            total++;
            if (t_seen !== exp_seq[k] || s_seen !== 1'b1) begin
                bad++;
                $display("FAIL steal_order%0d: trig=%b stolen=%b required %b/1", k, t_seen, s_seen, exp_seq[k]);
            end
        end
    endtask

    task automatic test_release_free();
        do_reset();
        send_event(1'b1, 60, 100, '0, "rel_on", t_seen, s_seen);
        send_event(1'b0, 60, 0, '0, "rel_off", t_seen, s_seen);
        pulse_done(4'b0001, "rel_done");
        send_event(1'b1, 72, 55, '0, "rel_reuse", t_seen, s_seen);
        total++;
        if (t_seen !== 4'b0001 || s_seen !== 1'b0) begin
            bad++;
            $display("FAIL reuse_freed: trig=%b stolen=%b required 0001/0", t_seen, s_seen);
        end
    endtask

    task automatic test_steal_releasing();
        int notes [4] = '{60, 62, 64, 65};
        do_reset();
        foreach (notes[k]) send_event(1'b1, notes[k], 70, '0, "sr_fill", t_seen, s_seen);
        send_event(1'b0, 64, 0, '0, "sr_off", t_seen, s_seen);
        send_event(1'b1, 69, 70, '0, "sr_on", t_seen, s_seen);
        total++;
        if (t_seen !== 4'b0100 || s_seen !== 1'b1) begin
            bad++;
            $display("FAIL steal_releasing: trig=%b stolen=%b required 0100/1", t_seen, s_seen);
        end
    endtask

    task automatic test_vel_zero();
        do_reset();
        send_event(1'b1, 48, 30, '0, "vz_a", t_seen, s_seen);
        send_event(1'b1, 60, 31, '0, "vz_b", t_seen, s_seen);
        send_event(1'b1, 60, 0, '0, "vz_off", t_seen, s_seen);
        total++;
        if (t_seen !== 4'b0000 || voice_gate !== 4'b0001) begin
            bad++;
            $display("FAIL vel0_noteoff: trig=%b gate=%b required 0000/0001", t_seen, voice_gate);
        end
        send_event(1'b0, 50, 0, '0, "vz_nomatch", t_seen, s_seen);
        total++;
        if (t_seen !== 4'b0000 || voice_gate !== 4'b0001) begin
            bad++;
            $display("FAIL off_nomatch: trig=%b gate=%b required 0000/0001", t_seen, voice_gate);
        end
    endtask

    task automatic test_commit_wins();
        do_reset();
        send_event(1'b1, 60, 50, '0, "cw_on", t_seen, s_seen);
        send_event(1'b0, 60, 0, '0, "cw_off", t_seen, s_seen);
        send_event(1'b1, 60, 90, 4'b0001, "cw_retrig", t_seen, s_seen);
        total++;
        if (voice_gate !== 4'b0001 || t_seen !== 4'b0001) begin
            bad++;
            $display("FAIL commit_wins: gate=%b trig=%b required 0001/0001", voice_gate, t_seen);
        end
    endtask

    task automatic test_panic_search();
        do_reset();
        send_event(1'b1, 60, 20, '0, "pn_a", t_seen, s_seen);
        send_event(1'b1, 62, 21, '0, "pn_b", t_seen, s_seen);
        send_event(1'b1, 64, 22, '0, "pn_c", t_seen, s_seen);
        bus.event_valid    = 1'b1;
        bus.event_on       = 1'b1;
        bus.event_note     = note_t'(65);
        bus.event_velocity = percent_t'(99);
        step();
        bus.event_valid = 1'b0;
        do_panic(2, "pn_search");
        for (int c = 0; c < 3; c++) begin
            step();
            total++;
            if (voice_trigger !== '0 || voice_note[3] !== '0) begin
                bad++;
                $display("FAIL panic_dropped%0d: trig=%b note3=%0d required 0000/0", c, voice_trigger, voice_note[3]);
            end
        end
        send_event(1'b1, 66, 40, '0, "pn_after", t_seen, s_seen);
    endtask

    task automatic test_random();
        do_reset();
        for (int it = 0; it < 300; it++) begin
            int r = $urandom_range(0, 9);
            if (r <= 4) begin
                int v = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 127);
                logic [VOICE_COUNT-1:0] cd = ($urandom_range(0, 3) == 0) ? VOICE_COUNT'($urandom_range(0, 15)) : '0;
                send_event(1'b1, 60 + $urandom_range(0, 7), v, cd, "rnd_on", t_seen, s_seen);
            end else if (r <= 6) begin
                send_event(1'b0, 60 + $urandom_range(0, 7), $urandom_range(0, 127), '0, "rnd_off", t_seen, s_seen);
            end else if (r <= 8) begin
                pulse_done(VOICE_COUNT'($urandom_range(0, 15)), "rnd_done");
            end else begin
                do_panic($urandom_range(1, 3), "rnd_panic");
            end
        end
    endtask

    initial begin
        bus.event_valid    = 1'b0;
        bus.event_on       = 1'b0;
        bus.event_note     = '0;
        bus.event_velocity = '0;
        test_reset();
        test_first_note();
        test_steal_oldest();
        test_release_free();
        test_steal_releasing();
        test_vel_zero();
        test_commit_wins();
        test_panic_search();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Scheduler that shares the CONFIG::PIPELINE_COUNT voice pipelines (oscillator + envelope) among incoming MIDI note events.
- Sits between the MIDI parser and the voice pipelines. Assigns each note-on to a voice, gates it off on note-off, and frees the voice when its envelope reports release complete.
- Steals the oldest voice when every voice is busy.

Parameters:
- VOICE_COUNT, CONFIG::PIPELINE_COUNT (4): number of voices scheduled.
- NOTE_WIDTH, 7: MIDI note number width.
- RANK_WIDTH, $clog2(VOICE_COUNT): age rank width.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- event_valid  in  1  note event present.
- event_ready  out  1  allocator can accept an event.
- event_on  in  1  1 = note-on, 0 = note-off.
- event_note  in  NOTE_WIDTH  MIDI note number.
- event_velocity  in  CONFIG::percent_t  velocity 0..127.
- panic  in  1  all-notes-off request, level-sampled.
- voice_done  in  VOICE_COUNT  per voice: envelope has reached zero after gate drop.
- voice_gate  out  VOICE_COUNT  per voice: key held.
- voice_trigger  out  VOICE_COUNT  per voice: 1-cycle pulse that restarts the envelope.
- voice_note  out  VOICE_COUNT x NOTE_WIDTH  note assigned to each voice.
- voice_velocity  out  VOICE_COUNT x percent_t  velocity latched per voice.
- voice_stolen  out  1  1-cycle pulse, coincident with a trigger that evicted a non-free voice.

Behaviour:
- Reset values:
  - All outputs 0, except event_ready = 1 once out of reset.
  - All voice states FREE.
  - Ranks are voice i = i (voice 0 oldest).
- Per-voice state:
  - FREE: gate 0.
  - GATED: gate 1.
  - RELEASING: gate 0, waiting on voice_done.
- Control FSM IDLE -> SEARCH -> COMMIT -> IDLE:
  - event_ready = 1 only in IDLE.
  - An event is accepted on the edge where valid & ready; it is latched and the FSM enters SEARCH.
  - SEARCH registers the target voice index plus a hit/steal flag.
  - COMMIT updates the voice registers.
  - Outputs change at the edge leaving COMMIT, so voice_trigger is high in cycle T+3 for an accept at edge T; event_ready is 1 again in that same cycle.
  - Maximum throughput is one event per 3 cycles.
- Note-on with velocity 0 is treated as a note-off.
- Note-on target priority:
  1. A GATED or RELEASING voice holding the same note (retrigger, no steal).
  2. The lowest-index FREE voice.
  3. The oldest (rank 0 first) RELEASING voice.
  4. The oldest GATED voice.
  - Cases 3 and 4 assert voice_stolen.
  - The target is set to GATED with note and velocity latched and voice_trigger pulsed.
- Age ranks:
  - The committed voice gets rank VOICE_COUNT-1.
  - Every voice whose rank is above the committed voice's old rank decrements by 1.
  - Ranks always form a permutation of 0..VOICE_COUNT-1, with no wrap.
- Note-off:
  - Matching GATED voice(s) go to RELEASING; note and velocity are kept.
  - No match: the event is consumed with no effect, and no trigger is issued.
- Release completion:
  - voice_done[i] moves voice i from RELEASING to FREE on the next edge.
  - voice_done is ignored while the voice is GATED or FREE.
  - If voice_done arrives in the same cycle as a COMMIT targeting that voice, the COMMIT wins.
- panic:
  - On any edge with panic = 1, all GATED voices go to RELEASING and the FSM returns to IDLE.
  - Any in-flight event is dropped.
  - event_ready is held at 0 while panic = 1.
- Asynchronous reset mid-event discards the event and restores the reset values.

Decomposition:
- CONFIG package gains:
  - NOTE_WIDTH = 7 and typedef note_t.
  - typedef voice_state_t enum {FREE, GATED, RELEASING}.
  - VOICE_COUNT is aliased to PIPELINE_COUNT.
- Sub-module voice_select: combinational priority and oldest-voice search over state, note and rank vectors. It returns the target index and the steal flag, and keeps the control FSM small.

Test Plan:
1. After reset, note-on 60 vel 100 at edge T -> voice_trigger = 0001 in cycle T+3, voice_gate[0] = 1, voice_note[0] = 60, voice_velocity[0] = 100, event_ready = 1 at T+3.
2. Five note-ons 60, 62, 64, 65, 67 -> voices 0-3 filled in order; note 67 steals voice 0 with voice_stolen = 1 and voice_note[0] = 67; rank order afterwards is 1, 2, 3, 0.
3. Note-on 60, note-off 60 -> gate[0] falls and the voice is RELEASING; voice_done[0] pulse -> FREE; next note-on 72 lands on voice 0 with no steal.
4. Fill all 4 voices, release voice 2 (note-off 64), then note-on 69 -> voice 2 chosen before any GATED voice, voice_stolen = 1.
5. Note-on 60 vel 0 while voice 1 is GATED on 60 -> treated as note-off: gate[1] = 0, no trigger; note-off 50 with no match -> no output change.
6. panic asserted during SEARCH of a note-on with 3 voices GATED -> all gates 0, the event is dropped (no trigger), event_ready = 0 until panic falls.
